// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the multiplier arbiter: FSM encoding and the default datapath width.
package mult_arbiter_pkg;

  localparam int WL_DEFAULT = 16;

  // IDLE wait for req | LOAD grant+latch | START pulse | ARM ignore busy | RUN wait busy low | DONE pulse
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_ARM,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Round-robin winner search: first requesting index after 'last', wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   winner,
  output logic            any
);

  logic [IW-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    w_idx  = '0;
    for (int off = NREQ; off >= 1; off--) begin
      w_idx = IW'((int'(last) + off) % NREQ);
      if (req[w_idx]) begin
        winner = w_idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates one shared sequential multiplier among NREQ PEs with round-robin grants.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int WORDLENGTH = WL_DEFAULT,
  parameter int NREQ       = 4
) (
  input  logic                       clk30x,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*WORDLENGTH-1:0] op_a,
  input  logic [NREQ*WORDLENGTH-1:0] op_b,
  output logic [NREQ-1:0]            grant,
  output logic [NREQ-1:0]            done,
  output logic [WORDLENGTH-1:0]      product,
  output logic                       mult_start,
  output logic [WORDLENGTH-1:0]      mult_a,
  output logic [WORDLENGTH-1:0]      mult_b,
  input  logic                       mult_busy,
  input  logic [WORDLENGTH-1:0]      mult_product
);

  localparam int              IW       = $clog2(NREQ);
  localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] LSB      = {{(NREQ-1){1'b0}}, 1'b1};

  state_t                r_state, w_state;
  logic [IW-1:0]         r_last, w_last;
  logic [IW-1:0]         r_winner, w_winner;
  logic [NREQ-1:0]       r_grant, w_grant;
  logic [NREQ-1:0]       r_done, w_done;
  logic                  r_start, w_start;
  logic [WORDLENGTH-1:0] r_mult_a, w_mult_a;
  logic [WORDLENGTH-1:0] r_mult_b, w_mult_b;
  logic [WORDLENGTH-1:0] r_product, w_product;

  logic [IW-1:0]         w_pick;
  logic                  w_any;
  logic [WORDLENGTH-1:0] w_a_arr [NREQ];
  logic [WORDLENGTH-1:0] w_b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_a_arr[g] = op_a[g*WORDLENGTH +: WORDLENGTH];
    assign w_b_arr[g] = op_b[g*WORDLENGTH +: WORDLENGTH];
  end

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .req    (req),
    .last   (r_last),
    .winner (w_pick),
    .any    (w_any)
  );

  // Outputs are registered: each transition computes the values seen in the next state.
  always_comb begin
    w_state   = r_state;
    w_last    = r_last;
    w_winner  = r_winner;
    w_grant   = r_grant;
    w_done    = '0;
    w_start   = 1'b0;
    w_mult_a  = r_mult_a;
    w_mult_b  = r_mult_b;
    w_product = r_product;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state  = ST_LOAD;
          w_winner = w_pick;
          w_last   = w_pick;
          w_grant  = LSB << w_pick;
          w_mult_a = w_a_arr[w_pick];
          w_mult_b = w_b_arr[w_pick];
        end
      end
      ST_LOAD: begin
        w_state = ST_START;
        w_start = 1'b1;
      end
      ST_START: w_state = ST_ARM;
      ST_ARM:   w_state = ST_RUN;
      ST_RUN: begin
        if (!mult_busy) begin
          w_state   = ST_DONE;
          w_product = mult_product;
          w_done    = LSB << r_winner;
          w_grant   = '0;
        end
      end
      ST_DONE:  w_state = ST_IDLE;
      default:  w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk30x or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_last    <= LAST_RST;
      r_winner  <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_start   <= 1'b0;
      r_mult_a  <= '0;
      r_mult_b  <= '0;
      r_product <= '0;
    end else begin
      r_state   <= w_state;
      r_last    <= w_last;
      r_winner  <= w_winner;
      r_grant   <= w_grant;
      r_done    <= w_done;
      r_start   <= w_start;
      r_mult_a  <= w_mult_a;
      r_mult_b  <= w_mult_b;
      r_product <= w_product;
    end
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign product    = r_product;
  assign mult_start = r_start;
  assign mult_a     = r_mult_a;
  assign mult_b     = r_mult_b;

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter WORDLENGTH, default 16, operand/product width in bits.
REQ-002 Parameter NREQ, default 4, number of requesting PEs (2..8).
REQ-003 clk30x  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-PE multiply request, level; held high until that PE's done pulse.
REQ-006 op_a  input  NREQ*WORDLENGTH  packed multiplicands; slice i belongs to PE i.
REQ-007 op_b  input  NREQ*WORDLENGTH  packed coefficients; slice i belongs to PE i.
REQ-008 grant  output  NREQ  one-hot owner of the shared multiplier; all zero when idle.
REQ-009 done  output  NREQ  one-cycle completion pulse to the owning PE.
REQ-010 product  output  WORDLENGTH  registered result; valid in the done cycle, held until the next completion.
REQ-011 mult_start  output  1  one-cycle start pulse to the sequential multiplier.
REQ-012 mult_a, mult_b  output  WORDLENGTH each  registered operands; stable from grant until done.
REQ-013 mult_busy  input  1  multiplier busy flag.
REQ-014 mult_product  input  WORDLENGTH  multiplier result, valid when busy falls.

Function
REQ-015 FSM states: IDLE, LOAD, START, ARM, RUN, DONE.
REQ-016 IDLE: if any req bit is high, choose winner, go to LOAD; else stay.
REQ-017 Winner: round-robin, search from (last_winner+1) mod NREQ upward with wrap; last_winner resets to NREQ-1, so PE0 wins first.
REQ-018 LOAD: set grant one-hot, latch op_a/op_b slices of winner into mult_a/mult_b, update last_winner, go to START.
REQ-019 START: mult_start=1 for exactly this cycle, go to ARM.
REQ-020 ARM: mult_busy ignored (multiplier raises busy late), go to RUN.
REQ-021 RUN: stay while mult_busy=1; on mult_busy=0 capture mult_product into product and go to DONE.
REQ-022 DONE: done[winner]=1 for one cycle, grant cleared, go to IDLE.
REQ-023 Minimum op length: LOAD to DONE = 5 cycles when busy is low in the first RUN cycle; a new grant is issued no earlier than 1 cycle after DONE.
REQ-024 req change mid-operation (drop or new request): no effect on current op; done still pulses for the granted PE.
REQ-025 Requests arriving in the same cycle are resolved only by the round-robin pointer; each of k continuously requesting PEs is served within k operations.
REQ-026 Single requester held continuously: served back-to-back, one op per IDLE pass.
REQ-027 No arithmetic in this block; product is passed through unmodified at WORDLENGTH bits.

Reset
REQ-028 Reset low: state=IDLE, grant=0, done=0, mult_start=0, mult_a=0, mult_b=0, product=0, last_winner=NREQ-1, immediately and asynchronously.
REQ-029 Reset mid-operation aborts the op: no done pulse; after release the interrupted PE re-arbitrates normally.

Structure
REQ-030 State encoding and WORDLENGTH default belong in the shared systolic package; NREQ stays a module parameter.
REQ-031 The round-robin winner search is one sub-module, rr_pick (req, last -> winner index, any); the rest is flat.

Verification
REQ-032 Reset release, req=0001, op_a0=3, op_b0=5, busy high 4 cycles after ARM -> grant=0001, one mult_start, mult_a=3, mult_b=5, done=0001 once, product=15.
REQ-033 req=1111 held, model mult returns a*b -> grant order 0001,0010,0100,1000,0001; no PE served twice before all four are served.
REQ-034 req0 dropped during RUN -> done[0] still pulses; no new grant to PE0 afterwards.
REQ-035 op_a0 changed from 3 to 9 during RUN -> mult_a stays 3, product=15.
REQ-036 Reset low during RUN with grant=0010 -> all outputs 0 at once; after release with req=0010 held, PE1 regranted, no stale done.
REQ-037 Busy never rises (instant multiplier) -> DONE 5 cycles after LOAD, product captured from mult_product.
